// File: rtl/wbs_burst_ram_if.sv
// Wishbone B3 bus bundle between a bench master and the burst RAM slave.
interface wbs_burst_ram_if;
  logic [31:0] adr_i;
  logic [1:0]  bte_i;
  logic [2:0]  cti_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic        we_i;
  logic        cyc_i;
  logic        stb_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport master (
    output adr_i, bte_i, cti_i, dat_i, sel_i, we_i, cyc_i, stb_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  adr_i, bte_i, cti_i, dat_i, sel_i, we_i, cyc_i, stb_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/wbs_burst_ram.sv
// Wishbone B3 slave RAM: classic cycles plus registered-feedback incrementing
// bursts (linear / wrap4 / wrap8 / wrap16) with byte-lane writes.
module wbs_burst_ram #(
  parameter int AW    = 12,
  parameter bit INIT0 = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  wbs_burst_ram_if.slave bus
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;

  // NOTE: the array is never reset; only the optional time-zero preset applies.
  logic [31:0] mem [DEPTH] = '{default: (INIT0 ? 32'h0 : {32{1'bx}})};

  state_t        state, state_d;
  logic          ack_q, ack_d;
  logic [AW-1:0] cnt, cnt_d, next_cnt, rd_addr;
  logic [31:0]   dat_q, rd_word;
  logic          load;
  logic          wr_en;
  logic          burst_end;
  logic          unused_adr;

  assign unused_adr = ^{bus.adr_i[31:AW+2], bus.adr_i[1:0]};

  assign bus.ack_o = ack_q & bus.cyc_i & bus.stb_i;
  assign bus.dat_o = dat_q;
  assign wr_en     = bus.ack_o & bus.we_i;
  assign burst_end = (bus.cti_i == 3'b111) || (bus.cti_i == 3'b000);

  // Wrap modes only advance the low bits; the block base is held.
  always_comb begin
    next_cnt = cnt + AW'(1);
    unique case (bus.bte_i)
      2'b01:   next_cnt = {cnt[AW-1:2], cnt[1:0] + 2'd1};
      2'b10:   next_cnt = {cnt[AW-1:3], cnt[2:0] + 3'd1};
      2'b11:   next_cnt = {cnt[AW-1:4], cnt[3:0] + 4'd1};
      default: next_cnt = cnt + AW'(1);
    endcase
  end

  // Prefetch read with bypass of the lanes being written this same edge.
  always_comb begin
    rd_word = mem[rd_addr];
    if (wr_en && (rd_addr == cnt)) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.sel_i[b]) rd_word[8*b +: 8] = bus.dat_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches are inferred.
    state_d = state;
    ack_d   = ack_q;
    cnt_d   = cnt;
    rd_addr = cnt;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cyc_i && bus.stb_i) begin
          cnt_d   = bus.adr_i[AW+1:2];
          rd_addr = bus.adr_i[AW+1:2];
          load    = 1'b1;
          ack_d   = 1'b1;
          state_d = (bus.cti_i == 3'b010) ? BURST : CLASSIC;
        end
      end
      CLASSIC: begin
        if (!bus.cyc_i || bus.ack_o) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      BURST: begin
        if (!bus.cyc_i || (bus.ack_o && burst_end)) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end else if (bus.ack_o) begin
          cnt_d   = next_cnt;
          rd_addr = next_cnt;
          load    = 1'b1;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ack_q <= 1'b0;
      cnt   <= '0;
      dat_q <= '0;
    end else begin
      state <= state_d;
      ack_q <= ack_d;
      cnt   <= cnt_d;
      if (load) dat_q <= rd_word;
    end
  end

  // Reset clears ack_q asynchronously, which also blocks a write in that cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.sel_i[b]) mem[cnt][8*b +: 8] <= bus.dat_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wbs_burst_ram.sv
// Directed bench for wbs_burst_ram: classic, wrap/linear bursts, wait states, reset.
module tb_wbs_burst_ram;

  typedef logic [31:0] word_arr_t [16];

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  wbs_burst_ram_if bus ();

  wbs_burst_ram #(.AW(12), .INIT0(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic idle_bus();
    bus.adr_i = '0; bus.bte_i = '0; bus.cti_i = '0; bus.dat_i = '0;
    bus.sel_i = '0; bus.we_i  = 1'b0; bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
  endtask

  // Single classic access; lat = cycles from request to ack (-1 on timeout).
  task automatic classic(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wd, output logic [31:0] rd, output int lat);
    bus.adr_i = adr; bus.we_i = we; bus.sel_i = sel; bus.dat_i = wd;
    bus.cti_i = 3'b000; bus.bte_i = 2'b00; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    lat = 0;
    #1;
    while (!bus.ack_o && lat < 16) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.ack_o) lat = -1;
    rd = bus.dat_o;
    @(posedge clk); #1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
  endtask

  // Full-rate burst of n beats; post_ack is ack_o one cycle after eob with cyc/stb still high.
  task automatic run_burst(input logic [31:0] adr, input logic [1:0] bte, input logic we,
                           input int n, input word_arr_t wd, output word_arr_t rd,
                           output int beats, output int gaps, output logic post_ack);
    bus.adr_i = adr; bus.bte_i = bte; bus.we_i = we; bus.sel_i = 4'hF;
    bus.dat_i = wd[0]; bus.cti_i = (n == 1) ? 3'b111 : 3'b010;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    beats = 0; gaps = 0;
    rd = '{default: '0};
    for (int c = 0; c < 64 && beats < n; c++) begin
      #1;
      if (bus.ack_o) begin
        rd[beats] = bus.dat_o;
        beats++;
      end else if (beats > 0) begin
        gaps++;
      end
      @(posedge clk); #1;
      if (beats < n) begin
        bus.dat_i = wd[beats];
        bus.cti_i = (beats == n - 1) ? 3'b111 : 3'b010;
      end
    end
    #1;
    post_ack = bus.ack_o;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.cti_i = 3'b000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    #1;
    vectors++;
    if (bus.ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.ack_o); end
    vectors++;
    if (bus.dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 00000000", bus.dat_o); end
    idle_bus();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_classic();
    logic [31:0] rd;
    int lat;
    classic(32'h100, 1'b1, 4'hF, 32'h12345678, rd, lat);
    vectors++;
    if (lat !== 1) begin errors++; $display("FAIL classic_wr_latency: got %0d want 1", lat); end
    // Back-to-back read request held across the dead cycle.
    bus.adr_i = 32'h100; bus.we_i = 1'b0; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    classic(32'h100, 1'b1, 4'hF, 32'h0, rd, lat);
    vectors++;
    if (lat !== 1) begin errors++; $display("FAIL classic_b2b_latency: got %0d want 1", lat); end
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = 32'h100;
    #1;
    vectors++;
    if (bus.ack_o !== 1'b0) begin errors++; $display("FAIL classic_dead_cycle: got %b want 0", bus.ack_o); end
    @(posedge clk); #1;
    vectors++;
    if (bus.ack_o !== 1'b1) begin errors++; $display("FAIL classic_rd_ack: got %b want 1", bus.ack_o); end
    vectors++;
    if (bus.dat_o !== 32'h0) begin errors++; $display("FAIL classic_rd_data0: got %h want 00000000", bus.dat_o); end
    @(posedge clk); #1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    // The b2b write above stored 0; restore and read the original value.
    classic(32'h100, 1'b1, 4'hF, 32'h12345678, rd, lat);
    classic(32'h100, 1'b0, 4'hF, 32'h0, rd, lat);
    vectors++;
    if (lat !== 1) begin errors++; $display("FAIL classic_rd_latency: got %0d want 1", lat); end
    vectors++;
    if (rd !== 32'h12345678) begin errors++; $display("FAIL classic_rd_data: got %h want 12345678", rd); end
  endtask

  task automatic test_beat4();
    word_arr_t wd, rd, exp;
    int beats, gaps, lat;
    logic post;
    logic [31:0] r;
    wd = '{default: '0};
    wd[0] = 32'h00010002; wd[1] = 32'h00030004; wd[2] = 32'h00050006; wd[3] = 32'h00070008;
    run_burst(32'hA000, 2'b01, 1'b1, 4, wd, rd, beats, gaps, post);
    vectors++;
    if (beats !== 4) begin errors++; $display("FAIL beat4_wr_beats: got %0d want 4", beats); end
    vectors++;
    if (gaps !== 0) begin errors++; $display("FAIL beat4_wr_gaps: got %0d want 0", gaps); end
    vectors++;
    if (post !== 1'b0) begin errors++; $display("FAIL beat4_wr_eob_ack: got %b want 0", post); end
    classic(32'hA008, 1'b1, 4'b1000, 32'hA1FFFFFF, r, lat);
    vectors++;
    if (lat !== 1) begin errors++; $display("FAIL lane_wr_latency: got %0d want 1", lat); end
    run_burst(32'hA008, 2'b01, 1'b0, 4, wd, rd, beats, gaps, post);
    exp = '{default: '0};
    exp[0] = 32'hA1050006; exp[1] = 32'h00070008; exp[2] = 32'h00010002; exp[3] = 32'h00030004;
    vectors++;
    if (beats !== 4 || gaps !== 0) begin
      errors++; $display("FAIL beat4_rd_timing: got beats %0d gaps %0d want 4 0", beats, gaps);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rd[i] !== exp[i]) begin errors++; $display("FAIL beat4_rd_data[%0d]: got %h want %h", i, rd[i], exp[i]); end
    end
  endtask

  task automatic test_linear();
    word_arr_t wd, rd;
    int beats, gaps, lat;
    logic post;
    logic [31:0] r;
    wd = '{default: '0};
    wd[0] = 32'hDEADDEAD; wd[1] = 32'h55555555;
    run_burst(32'h1000, 2'b00, 1'b1, 2, wd, rd, beats, gaps, post);
    run_burst(32'h1000, 2'b00, 1'b0, 2, wd, rd, beats, gaps, post);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (rd[i] !== wd[i]) begin errors++; $display("FAIL linear_rd[%0d]: got %h want %h", i, rd[i], wd[i]); end
    end
    classic(32'h1008, 1'b0, 4'hF, 32'h0, r, lat);
    vectors++;
    if (r !== 32'h0) begin errors++; $display("FAIL linear_no_spill: got %h want 00000000", r); end
    // Last word of the array rolls over to word 0.
    wd[0] = 32'hF00DF00D; wd[1] = 32'h0BADC0DE;
    run_burst(32'h3FFC, 2'b00, 1'b1, 2, wd, rd, beats, gaps, post);
    classic(32'h4000, 1'b0, 4'hF, 32'h0, r, lat);
    vectors++;
    if (r !== 32'h0BADC0DE) begin errors++; $display("FAIL linear_rollover: got %h want 0badc0de", r); end
  endtask

  task automatic test_wait_state();
    word_arr_t wd, rd;
    int beats, gaps, lat;
    logic post;
    int order [8] = '{6, 7, 0, 1, 2, 3, 4, 5};
    for (int i = 0; i < 16; i++) wd[i] = 32'hB0B00000 + i;
    run_burst(32'h200, 2'b10, 1'b1, 8, wd, rd, beats, gaps, post);
    bus.adr_i = 32'h218; bus.bte_i = 2'b10; bus.we_i = 1'b0; bus.cti_i = 3'b010;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    lat = 0;
    #1;
    while (!bus.ack_o && lat < 16) begin
      @(posedge clk); #1; lat++;
    end
    vectors++;
    if (lat !== 1) begin errors++; $display("FAIL wait_first_latency: got %0d want 1", lat); end
    vectors++;
    if (bus.dat_o !== 32'hB0B00006) begin errors++; $display("FAIL wait_beat0: got %h want b0b00006", bus.dat_o); end
    @(posedge clk); #1;
    bus.stb_i = 1'b0;
    for (int g = 0; g < 2; g++) begin
      #1;
      vectors++;
      if (bus.ack_o !== 1'b0 || bus.dat_o !== 32'hB0B00007) begin
        errors++; $display("FAIL wait_gap%0d: got ack %b dat %h want 0 b0b00007", g, bus.ack_o, bus.dat_o);
      end
      @(posedge clk); #1;
    end
    bus.stb_i = 1'b1;
    for (int k = 1; k < 8; k++) begin
      if (k == 7) bus.cti_i = 3'b111;
      #1;
      vectors++;
      if (bus.ack_o !== 1'b1 || bus.dat_o !== (32'hB0B00000 + order[k])) begin
        errors++;
        $display("FAIL wait_beat%0d: got ack %b dat %h want 1 %h", k, bus.ack_o, bus.dat_o, 32'hB0B00000 + order[k]);
      end
      @(posedge clk); #1;
    end
    #1;
    vectors++;
    if (bus.ack_o !== 1'b0) begin errors++; $display("FAIL wait_eob_ack: got %b want 0", bus.ack_o); end
    idle_bus();
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] r;
    int lat;
    classic(32'h304, 1'b1, 4'hF, 32'hCAFEF00D, r, lat);
    bus.adr_i = 32'h300; bus.bte_i = 2'b00; bus.we_i = 1'b1; bus.sel_i = 4'hF;
    bus.dat_i = 32'h11111111; bus.cti_i = 3'b010; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    lat = 0;
    #1;
    while (!bus.ack_o && lat < 16) begin
      @(posedge clk); #1; lat++;
    end
    @(posedge clk); #1;
    bus.dat_i = 32'h22222222;
    #1;
    vectors++;
    if (bus.ack_o !== 1'b1) begin errors++; $display("FAIL rst_beat2_ack: got %b want 1", bus.ack_o); end
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.ack_o !== 1'b0) begin errors++; $display("FAIL rst_async_ack: got %b want 0", bus.ack_o); end
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    classic(32'h304, 1'b0, 4'hF, 32'h0, r, lat);
    vectors++;
    if (lat !== 1) begin errors++; $display("FAIL rst_after_latency: got %0d want 1", lat); end
    vectors++;
    if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_beat2_word: got %h want cafef00d", r); end
    classic(32'h300, 1'b0, 4'hF, 32'h0, r, lat);
    vectors++;
    if (r !== 32'h11111111) begin errors++; $display("FAIL rst_beat1_word: got %h want 11111111", r); end
  endtask

  initial begin
    test_reset();
    test_classic();
    test_beat4();
    test_linear();
    test_wait_state();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout want completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

endmodule
